// File: rtl/usb_reg_pkg.sv
// usb_reg_pkg: shared constants and state encoding for the 8-bit parallel
// register-bus master (usb_reg_master) and its helpers.
package usb_reg_pkg;

  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned LEN_W_DEF    = 7;
  localparam int unsigned ALE_CYC_DEF  = 2;
  localparam int unsigned STB_CYC_DEF  = 3;
  localparam int unsigned GAP_CYC_DEF  = 2;
  localparam int unsigned TMR_W        = 8;
  localparam int unsigned STAT_TXN_W   = 16;
  localparam int unsigned STAT_BYTES_W = 24;

  // Bus master phase encoding
  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_ALE_ENC     = 3'd1;
  localparam logic [2:0] ST_WAIT_WR_ENC = 3'd2;
  localparam logic [2:0] ST_STB_ENC     = 3'd3;
  localparam logic [2:0] ST_GAP_ENC     = 3'd4;
  localparam logic [2:0] ST_DONE_ENC    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_ALE     = ST_ALE_ENC,
    ST_WAIT_WR = ST_WAIT_WR_ENC,
    ST_STB     = ST_STB_ENC,
    ST_GAP     = ST_GAP_ENC,
    ST_DONE    = ST_DONE_ENC
  } state_t;

  // Timer load value for a phase lasting cyc cycles (timer counts load..0)
  function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cyc);
    return (cyc == 0) ? '0 : TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/usb_reg_master_if.sv
// usb_reg_master_if: command / write-data / read-data streams plus the
// parallel register bus pins of usb_reg_master.
//   master modport : view of usb_reg_master (drives strobes, cmd_ready, ...)
//   slave  modport : view of the command source and bus responder
interface usb_reg_master_if #(
  parameter int unsigned pLEN_W = 7
) ();
  import usb_reg_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [pLEN_W-1:0] cmd_len;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic [ADDR_W-1:0] usb_addr;
  logic [DATA_W-1:0] usb_dout;
  logic              usb_doe;
  logic [DATA_W-1:0] usb_din;
  logic              usb_rdn;
  logic              usb_wrn;
  logic              usb_cen;
  logic              usb_alen;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, usb_din,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy,
           usb_addr, usb_dout, usb_doe, usb_rdn, usb_wrn, usb_cen, usb_alen
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, usb_din,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy,
           usb_addr, usb_dout, usb_doe, usb_rdn, usb_wrn, usb_cen, usb_alen
  );

endinterface

// File: rtl/usb_reg_master_timer.sv
// usb_reg_master_timer: loadable down-counter timing the ALE, STB and GAP
// phases. done_c is high while the count is zero (last cycle of a phase).
//   clk_usb, reset_n : clock, async active-low reset
//   load, load_val   : load count (takes priority over counting)
//   done_c           : count == 0
module usb_reg_master_timer
  import usb_reg_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk_usb,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt;

  // Count down to zero and hold there until reloaded
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/usb_reg_master.sv
// usb_reg_master: initiator for the 8-bit parallel register bus answered by
// usb_reg_main. Turns a valid/ready command (addr, direction, byte count)
// into ALEn / CEn / RDn / WRn strobe sequences; write bytes come from the
// wr_* stream, read bytes leave on rd_valid/rd_data (no back-pressure).
//   clk_usb, reset_n : clock, async active-low reset
//   bus (master)     : command, write/read streams, busy, USB bus pins
// Optional build macro USB_REG_MASTER_STATS_EN adds stat_clr (in),
// stat_txn[15:0] and stat_bytes[23:0] (out), saturating counters of
// completed transactions and issued strobes.
module usb_reg_master
  import usb_reg_pkg::*;
#(
  parameter int unsigned pLEN_W   = LEN_W_DEF,
  parameter int unsigned pALE_CYC = ALE_CYC_DEF,
  parameter int unsigned pSTB_CYC = STB_CYC_DEF,
  parameter int unsigned pGAP_CYC = GAP_CYC_DEF
) (
  input  logic                    clk_usb,
  input  logic                    reset_n,
`ifdef USB_REG_MASTER_STATS_EN
  input  logic                    stat_clr,
  output logic [STAT_TXN_W-1:0]   stat_txn,
  output logic [STAT_BYTES_W-1:0] stat_bytes,
`endif
  usb_reg_master_if.master        bus
);

  localparam logic [TMR_W-1:0] ALE_LD = tmr_load(pALE_CYC);
  localparam logic [TMR_W-1:0] STB_LD = tmr_load(pSTB_CYC);
  localparam logic [TMR_W-1:0] GAP_LD = tmr_load(pGAP_CYC);

  state_t            state;
  logic              wr_mode;
  logic [pLEN_W-1:0] remain;

  logic              tmr_done_c;
  logic              tmr_load_c;
  logic [TMR_W-1:0]  tmr_val_c;
  logic              accept_c;
  logic              wr_take_c;
  logic              last_byte_c;
  logic              stb_start_c;

  assign accept_c    = (state == ST_IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign wr_take_c   = (state == ST_WAIT_WR) && bus.wr_valid && bus.wr_ready;
  assign last_byte_c = (remain == pLEN_W'(1));
  // A strobe goes low on the next edge: write byte taken, or read phase begins
  assign stb_start_c = wr_take_c ||
                       (tmr_done_c && !wr_mode &&
                        ((state == ST_ALE) || ((state == ST_GAP) && !last_byte_c)));

  // Timer reload on every phase entry
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = STB_LD;
    if (accept_c) begin
      tmr_load_c = 1'b1;
      tmr_val_c  = ALE_LD;
    end else if ((state == ST_STB) && tmr_done_c) begin
      tmr_load_c = 1'b1;
      tmr_val_c  = GAP_LD;
    end else if (stb_start_c) begin
      tmr_load_c = 1'b1;
      tmr_val_c  = STB_LD;
    end
  end

  usb_reg_master_timer #(.W(TMR_W)) u_timer (
    .clk_usb  (clk_usb),
    .reset_n  (reset_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c)
  );

  // Transaction sequencer; all bus and stream outputs registered here
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      wr_mode       <= 1'b0;
      remain        <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.wr_ready  <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.usb_addr  <= '0;
      bus.usb_dout  <= '0;
      bus.usb_doe   <= 1'b0;
      bus.usb_rdn   <= 1'b1;
      bus.usb_wrn   <= 1'b1;
      bus.usb_cen   <= 1'b1;
      bus.usb_alen  <= 1'b1;
    end else begin
      bus.rd_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept_c) begin
            wr_mode       <= bus.cmd_write;
            remain        <= (bus.cmd_len == '0) ? pLEN_W'(1) : bus.cmd_len;
            bus.usb_addr  <= bus.cmd_addr;
            bus.usb_alen  <= 1'b0;
            bus.usb_cen   <= 1'b0;
            bus.busy      <= 1'b1;
            bus.cmd_ready <= 1'b0;
            state         <= ST_ALE;
          end
        end
        ST_ALE: begin
          if (tmr_done_c) begin
            bus.usb_alen <= 1'b1;
            if (wr_mode) begin
              bus.wr_ready <= 1'b1;
              state        <= ST_WAIT_WR;
            end else begin
              bus.usb_rdn <= 1'b0;
              bus.usb_doe <= 1'b0;
              state       <= ST_STB;
            end
          end
        end
        ST_WAIT_WR: begin
          if (wr_take_c) begin
            bus.usb_dout <= bus.wr_data;
            bus.usb_doe  <= 1'b1;
            bus.usb_wrn  <= 1'b0;
            bus.wr_ready <= 1'b0;
            state        <= ST_STB;
          end
        end
        ST_STB: begin
          // Read byte is captured on the last low cycle of RDn
          if (tmr_done_c) begin
            bus.usb_rdn <= 1'b1;
            bus.usb_wrn <= 1'b1;
            if (!wr_mode) begin
              bus.rd_data  <= bus.usb_din;
              bus.rd_valid <= 1'b1;
            end
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Drive data stays on the bus for one cycle after WRn rises
          bus.usb_doe <= 1'b0;
          if (tmr_done_c) begin
            if (last_byte_c) begin
              state <= ST_DONE;
            end else begin
              remain <= remain - pLEN_W'(1);
              if (wr_mode) begin
                bus.wr_ready <= 1'b1;
                state        <= ST_WAIT_WR;
              end else begin
                bus.usb_rdn <= 1'b0;
                state       <= ST_STB;
              end
            end
          end
        end
        ST_DONE: begin
          bus.usb_cen   <= 1'b1;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef USB_REG_MASTER_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      stat_txn   <= '0;
      stat_bytes <= '0;
    end else if (stat_clr) begin
      stat_txn   <= '0;
      stat_bytes <= '0;
    end else begin
      if ((state == ST_DONE) && (stat_txn != '1)) begin
        stat_txn <= stat_txn + STAT_TXN_W'(1);
      end
      if (stb_start_c && (stat_bytes != '1)) begin
        stat_bytes <= stat_bytes + STAT_BYTES_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb_reg_master.sv
// tb_usb_reg_master: directed bench for usb_reg_master with a bus responder
// model and scoreboard queues for addresses, write bytes, read bytes and
// per-transaction strobe counts.
module tb_usb_reg_master;
  import usb_reg_pkg::*;

  localparam int unsigned LEN_W = LEN_W_DEF;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_exp_t;

  logic clk_usb = 1'b0;
  logic reset_n;
  always #5 clk_usb = ~clk_usb;

  usb_reg_master_if #(.pLEN_W(LEN_W)) bif ();

`ifdef USB_REG_MASTER_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_txn;
  logic [23:0] stat_bytes;
`endif

  usb_reg_master #(
    .pLEN_W   (LEN_W),
    .pALE_CYC (ALE_CYC_DEF),
    .pSTB_CYC (STB_CYC_DEF),
    .pGAP_CYC (GAP_CYC_DEF)
  ) dut (
    .clk_usb    (clk_usb),
    .reset_n    (reset_n),
`ifdef USB_REG_MASTER_STATS_EN
    .stat_clr   (stat_clr),
    .stat_txn   (stat_txn),
    .stat_bytes (stat_bytes),
`endif
    .bus        (bif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  wr_exp_t    exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_addr[$];
  int         exp_stb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Responder: byte counter cleared by ALEn, advanced on each strobe release
  logic [7:0] resp_base = 8'h00;
  logic [7:0] resp_cnt  = 8'h00;
  logic       r_prev_rdn = 1'b1;
  logic       r_prev_wrn = 1'b1;

  always @(posedge clk_usb) begin
    if (!bif.usb_alen) resp_cnt <= 8'h00;
    else if ((!r_prev_rdn && bif.usb_rdn) || (!r_prev_wrn && bif.usb_wrn)) resp_cnt <= resp_cnt + 8'd1;
    r_prev_rdn <= bif.usb_rdn;
    r_prev_wrn <= bif.usb_wrn;
  end

  assign bif.usb_din = 8'(resp_base + resp_cnt);

  // Bus monitor
  logic       m_rdn = 1'b1, m_wrn = 1'b1, m_alen = 1'b1, m_busy = 1'b0;
  int         w_rdn = 0, w_wrn = 0, w_alen = 0, stb_cnt = 0;
  logic [7:0] cur_wr = 8'h00;

  always @(negedge clk_usb) begin
    if (!reset_n) begin
      m_rdn = 1'b1; m_wrn = 1'b1; m_alen = 1'b1; m_busy = 1'b0;
      w_rdn = 0; w_wrn = 0; w_alen = 0; stb_cnt = 0;
    end else begin
      check("strobe_excl", 32'(bif.usb_rdn | bif.usb_wrn), 32'd1);
      check("doe_during_rd", 32'(bif.usb_doe & ~bif.usb_rdn), 32'd0);
      if (m_alen && !bif.usb_alen) begin
        check("ale_expected", 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) check("ale_addr", 32'(bif.usb_addr), 32'(exp_addr.pop_front()));
      end
      if (!bif.usb_alen) w_alen++;
      if (!m_alen && bif.usb_alen) begin
        check("ale_width", 32'(w_alen), 32'(ALE_CYC_DEF));
        w_alen = 0;
      end
      if (m_rdn && !bif.usb_rdn) stb_cnt++;
      if (!bif.usb_rdn) w_rdn++;
      if (!m_rdn && bif.usb_rdn) begin
        check("rdn_width", 32'(w_rdn), 32'(STB_CYC_DEF));
        w_rdn = 0;
      end
      if (m_wrn && !bif.usb_wrn) begin
        stb_cnt++;
        check("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          wr_exp_t e;
          e = exp_wr.pop_front();
          cur_wr = e.data;
          check("wr_dout", 32'(bif.usb_dout), 32'(e.data));
          check("wr_doe", 32'(bif.usb_doe), 32'd1);
          check("resp_bytecnt", 32'(resp_cnt), 32'(e.idx));
        end
      end
      if (!bif.usb_wrn) w_wrn++;
      if (!m_wrn && bif.usb_wrn) begin
        check("wrn_width", 32'(w_wrn), 32'(STB_CYC_DEF));
        check("wr_hold_doe", 32'(bif.usb_doe), 32'd1);
        check("wr_hold_dout", 32'(bif.usb_dout), 32'(cur_wr));
        w_wrn = 0;
      end
      if (bif.rd_valid) begin
        check("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) check("rd_data", 32'(bif.rd_data), 32'(exp_rd.pop_front()));
      end
      if (!m_busy && bif.busy) stb_cnt = 0;
      if (m_busy && !bif.busy) begin
        check("stb_expected", 32'(exp_stb.size() > 0), 32'd1);
        if (exp_stb.size() > 0) check("stb_count", 32'(stb_cnt), 32'(exp_stb.pop_front()));
      end
      m_rdn = bif.usb_rdn; m_wrn = bif.usb_wrn; m_alen = bif.usb_alen; m_busy = bif.busy;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_strobes"}, 32'({bif.usb_rdn, bif.usb_wrn, bif.usb_cen, bif.usb_alen}), 32'hF);
    check({tag, "_doe"}, 32'(bif.usb_doe), 32'd0);
    check({tag, "_addr"}, 32'(bif.usb_addr), 32'd0);
    check({tag, "_dout"}, 32'(bif.usb_dout), 32'd0);
    check({tag, "_cmd_ready"}, 32'(bif.cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(bif.busy), 32'd0);
    check({tag, "_wr_ready"}, 32'(bif.wr_ready), 32'd0);
    check({tag, "_rd_valid"}, 32'(bif.rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(bif.rd_data), 32'd0);
  endtask

  task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [LEN_W-1:0] len);
    int t;
    exp_addr.push_back(addr);
    exp_stb.push_back((len == '0) ? 1 : int'(len));
    t = 0;
    while (!bif.cmd_ready && t < 300) begin @(negedge clk_usb); t++; end
    check("cmd_ready_wait", 32'(bif.cmd_ready), 32'd1);
    bif.cmd_valid = 1'b1; bif.cmd_write = wr; bif.cmd_addr = addr; bif.cmd_len = len;
    @(negedge clk_usb);
    bif.cmd_valid = 1'b0;
    check("acc_busy", 32'(bif.busy), 32'd1);
    check("acc_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    check("acc_cen", 32'(bif.usb_cen), 32'd0);
    check("acc_alen", 32'(bif.usb_alen), 32'd0);
    check("acc_addr", 32'(bif.usb_addr), 32'(addr));
  endtask

  task automatic feed_wr(input logic [7:0] d);
    int t;
    t = 0;
    while (!bif.wr_ready && t < 300) begin @(negedge clk_usb); t++; end
    check("wr_ready_wait", 32'(bif.wr_ready), 32'd1);
    bif.wr_valid = 1'b1; bif.wr_data = d;
    @(negedge clk_usb);
    bif.wr_valid = 1'b0;
    check("wr_ready_drop", 32'(bif.wr_ready), 32'd0);
  endtask

  task automatic wait_idle(input bit no_doe);
    int t;
    t = 0;
    while (bif.busy && t < 300) begin
      @(negedge clk_usb);
      if (no_doe) check("rd_doe_low", 32'(bif.usb_doe), 32'd0);
      t++;
    end
    check("idle_busy", 32'(bif.busy), 32'd0);
    check("idle_cen", 32'(bif.usb_cen), 32'd1);
    check("idle_cmd_ready", 32'(bif.cmd_ready), 32'd1);
  endtask

  logic [7:0] wdat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  initial begin
    int falls;
    int t;
    logic p;
    reset_n = 1'b0;
    bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = 8'h00; bif.cmd_len = '0;
    bif.wr_valid = 1'b0; bif.wr_data = 8'h00;
`ifdef USB_REG_MASTER_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(negedge clk_usb);
    check_reset_state("por");
    reset_n = 1'b1;
    @(negedge clk_usb);

    // 4-byte write
    for (int i = 0; i < 4; i++) exp_wr.push_back('{i, wdat[i]});
    do_cmd(1'b1, 8'h10, LEN_W'(4));
    for (int i = 0; i < 4; i++) feed_wr(wdat[i]);
    wait_idle(1'b0);

    // 3-byte read
    resp_base = 8'h5A;
    for (int i = 0; i < 3; i++) exp_rd.push_back(8'(8'h5A + i));
    do_cmd(1'b0, 8'h22, LEN_W'(3));
    wait_idle(1'b1);
    check("rd_all_returned", 32'(exp_rd.size()), 32'd0);

    // Write with stalled data
    exp_wr.push_back('{0, 8'h77});
    do_cmd(1'b1, 8'h33, LEN_W'(1));
    t = 0;
    while (!bif.wr_ready && t < 300) begin @(negedge clk_usb); t++; end
    check("stall_wr_ready", 32'(bif.wr_ready), 32'd1);
    repeat (10) begin
      @(negedge clk_usb);
      check("stall_wrn_high", 32'(bif.usb_wrn), 32'd1);
      check("stall_cen_low", 32'(bif.usb_cen), 32'd0);
    end
    bif.wr_valid = 1'b1; bif.wr_data = 8'h77;
    @(negedge clk_usb);
    bif.wr_valid = 1'b0;
    check("stall_wrn_start", 32'(bif.usb_wrn), 32'd0);
    wait_idle(1'b0);

    // Zero length read behaves as one byte; commands during busy are ignored
    resp_base = 8'h90;
    exp_rd.push_back(8'h90);
    do_cmd(1'b0, 8'h44, LEN_W'(0));
    bif.cmd_valid = 1'b1; bif.cmd_addr = 8'hEE; bif.cmd_len = LEN_W'(5);
    repeat (3) begin
      @(negedge clk_usb);
      check("busy_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    end
    bif.cmd_valid = 1'b0;
    wait_idle(1'b1);
    repeat (5) begin
      @(negedge clk_usb);
      check("len0_stays_idle", 32'(bif.busy), 32'd0);
    end
    check("len0_rd_returned", 32'(exp_rd.size()), 32'd0);

    // Reset during the second strobe of a 4-byte read
    resp_base = 8'h20;
    for (int i = 0; i < 4; i++) exp_rd.push_back(8'(8'h20 + i));
    do_cmd(1'b0, 8'h55, LEN_W'(4));
    falls = 0; t = 0; p = bif.usb_rdn;
    while (falls < 2 && t < 300) begin
      @(negedge clk_usb);
      if (p && !bif.usb_rdn) falls++;
      p = bif.usb_rdn;
      t++;
    end
    check("rst_reach_2nd_stb", 32'(falls), 32'd2);
    #2 reset_n = 1'b0;
    #1 check_reset_state("midrst");
    exp_rd.delete(); exp_stb.delete(); exp_addr.delete();
    repeat (3) begin
      @(negedge clk_usb);
      check("midrst_no_rd_valid", 32'(bif.rd_valid), 32'd0);
    end
    reset_n = 1'b1;
    resp_base = 8'hC0;
    exp_rd.push_back(8'hC0); exp_rd.push_back(8'hC1);
    do_cmd(1'b0, 8'h66, LEN_W'(2));
    wait_idle(1'b1);
    check("post_rst_rd_returned", 32'(exp_rd.size()), 32'd0);

`ifdef USB_REG_MASTER_STATS_EN
    stat_clr = 1'b1;
    @(negedge clk_usb);
    stat_clr = 1'b0;
    for (int i = 0; i < 4; i++) exp_wr.push_back('{i, wdat[i]});
    do_cmd(1'b1, 8'h11, LEN_W'(4));
    for (int i = 0; i < 4; i++) feed_wr(wdat[i]);
    wait_idle(1'b0);
    resp_base = 8'h01;
    for (int i = 0; i < 3; i++) exp_rd.push_back(8'(8'h01 + i));
    do_cmd(1'b0, 8'h12, LEN_W'(3));
    wait_idle(1'b1);
    @(negedge clk_usb);
    check("stat_txn", 32'(stat_txn), 32'd2);
    check("stat_bytes", 32'(stat_bytes), 32'd7);
    stat_clr = 1'b1;
    @(negedge clk_usb);
    stat_clr = 1'b0;
    check("stat_txn_clr", 32'(stat_txn), 32'd0);
    check("stat_bytes_clr", 32'(stat_bytes), 32'd0);
`endif

    repeat (3) @(negedge clk_usb);
    check("end_wr_queue", 32'(exp_wr.size()), 32'd0);
    check("end_stb_queue", 32'(exp_stb.size()), 32'd0);
    check("end_addr_queue", 32'(exp_addr.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
